// File: rtl/seq_addsub.sv
// ---------------------------------------------------------------------------
// seq_addsub
// Sequential two's-complement adder/subtractor. An operation is accepted in
// IDLE, then worked through CHUNK bits per clock in RUN, least-significant
// chunk first. After NCHUNK clocks the result and flags are presented in
// DONE until the consumer takes them.
//
// Parameters
//   WIDTH      operand/result width in bits (must be a multiple of CHUNK)
//   CHUNK      bits processed per clock; CHUNK == WIDTH gives 1-cycle latency
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   a, b and sub are valid
//   in_ready   block is idle and can accept an operation
//   a, b       operands (two's complement)
//   sub        0 = a + b, 1 = a - b
//   out_valid  result and flags are valid
//   out_ready  consumer takes the result
//   result     sum / difference
//   cout       carry out of the MSB (on subtract: 1 = no borrow)
//   ovf        signed overflow
//   zero       result equals zero
//
// Configuration
//   SEQ_ADDSUB_SAT_EN  when defined, an overflowing result saturates to the
//                      most positive / most negative value instead of
//                      wrapping; ovf still reports the overflow.
// ---------------------------------------------------------------------------
module seq_addsub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NCHUNK - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

`ifdef SEQ_ADDSUB_SAT_EN
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             carry;

    // Operand shift registers: the chunk being worked on is always in the
    // low CHUNK bits, so no variable part-selects are needed. b is stored
    // already inverted for subtraction (a - b = a + ~b + 1).
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;

    // Partial result assembled from the top down; each new chunk enters at
    // the MSB end, so after NCHUNK steps every chunk sits in its place.
    logic [WIDTH-1:0] acc;

    logic [WIDTH-1:0] result_q;
    logic             cout_q;
    logic             ovf_q;
    logic             zero_q;

    logic [CHUNK:0]         chunk_sum;
    logic [WIDTH+CHUNK-1:0] assembled;
    logic [WIDTH-1:0]       acc_next;
    logic                   last_ovf;
    logic [WIDTH-1:0]       final_res;

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign result    = result_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

    // One chunk of the ripple: current low chunks of both operands plus the
    // carry left over from the previous chunk. On the final chunk the low
    // bits of a_sh/b_sh hold the original top chunk, so their bit CHUNK-1
    // is the operand sign bit. Overflow occurs when both addends share a
    // sign and the sum's sign differs, which equals carry-in XOR carry-out
    // of the MSB.
    always_comb begin
        chunk_sum = {1'b0, a_sh[CHUNK-1:0]}
                  + {1'b0, b_sh[CHUNK-1:0]}
                  + {{CHUNK{1'b0}}, carry};
        assembled = {chunk_sum[CHUNK-1:0], acc};
        acc_next  = assembled[WIDTH+CHUNK-1:CHUNK];
        last_ovf  = (a_sh[CHUNK-1] == b_sh[CHUNK-1]) &&
                    (chunk_sum[CHUNK-1] != a_sh[CHUNK-1]);
        final_res = acc_next;
`ifdef SEQ_ADDSUB_SAT_EN
        // Overflow direction follows the sign of a: positive a can only
        // overflow upwards, negative a only downwards.
        if (last_ovf) begin
            final_res = a_sh[CHUNK-1] ? SAT_MIN : SAT_MAX;
        end
`endif
    end

    // Control FSM and datapath registers. The visible result/flags are only
    // updated on the edge that finishes the last chunk, so they stay stable
    // for the whole of DONE and keep the previous values during RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            carry    <= 1'b0;
            a_sh     <= '0;
            b_sh     <= '0;
            acc      <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_sh  <= a;
                        b_sh  <= b ^ {WIDTH{sub}};
                        carry <= sub;
                        cnt   <= '0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    a_sh  <= a_sh >> CHUNK;
                    b_sh  <= b_sh >> CHUNK;
                    acc   <= acc_next;
                    carry <= chunk_sum[CHUNK];
                    if (cnt == LAST_CHUNK) begin
                        cnt      <= '0;
                        result_q <= final_res;
                        cout_q   <= chunk_sum[CHUNK];
                        ovf_q    <= last_ovf;
                        zero_q   <= (final_res == '0);
                        state    <= S_DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_addsub.sv
// ---------------------------------------------------------------------------
// tb_seq_addsub
// Self-checking bench for seq_addsub (WIDTH=16, CHUNK=4, plus a CHUNK=16
// instance). A behavioural model derives the expected result and flags from
// integer arithmetic; a compare process checks the DUT against it on every
// cycle, and directed vectors pin the model with hand-computed values.
// Honours SEQ_ADDSUB_SAT_EN in the model and literal expectations.
// ---------------------------------------------------------------------------
module tb_seq_addsub;

    localparam int WIDTH  = 16;
    localparam int CHUNK  = 4;
    localparam int NCHUNK = WIDTH / CHUNK;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic              sub;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  result;
    logic              cout;
    logic              ovf;
    logic              zero;

    logic              in_valid_w;
    logic              in_ready_w;
    logic [WIDTH-1:0]  a_w;
    logic [WIDTH-1:0]  b_w;
    logic              sub_w;
    logic              out_valid_w;
    logic              out_ready_w;
    logic [WIDTH-1:0]  result_w;
    logic              cout_w;
    logic              ovf_w;
    logic              zero_w;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    seq_addsub #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    seq_addsub #(.WIDTH(WIDTH), .CHUNK(WIDTH)) dut_wide (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid_w),
        .in_ready  (in_ready_w),
        .a         (a_w),
        .b         (b_w),
        .sub       (sub_w),
        .out_valid (out_valid_w),
        .out_ready (out_ready_w),
        .result    (result_w),
        .cout      (cout_w),
        .ovf       (ovf_w),
        .zero      (zero_w)
    );

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Expected {result, cout, ovf, zero} from plain integer arithmetic.
    function automatic logic [18:0] model(input logic [15:0] aa, input logic [15:0] bb, input logic ss);
        int sa;
        int sb;
        int ua;
        int ub;
        int t;
        logic [15:0] r;
        logic c;
        logic o;
        sa = int'($signed(aa));
        sb = int'($signed(bb));
        ua = int'(aa);
        ub = int'(bb);
        t  = ss ? (sa - sb) : (sa + sb);
        c  = ss ? (ua >= ub) : ((ua + ub) > 65535);
        o  = (t > 32767) || (t < -32768);
        r  = t[15:0];
`ifdef SEQ_ADDSUB_SAT_EN
        if (o) r = (t > 0) ? 16'h7FFF : 16'h8000;
`endif
        return {r, c, o, (r == 16'h0000)};
    endfunction

    // Compare process: tracks the one outstanding operation and checks the
    // handshake and outputs every cycle away from the active edge.
    logic        pend = 1'b0;
    logic        first = 1'b0;
    logic [18:0] exp_q = '0;
    int          acc_cyc = 0;

    always @(negedge clk) begin
        if (rst) begin
            pend = 1'b0;
        end else begin
            checkVal("mon_in_ready", {31'b0, in_ready}, {31'b0, !pend});
            if (pend) begin
                if (out_valid) begin
                    if (first) begin
                        checkVal("mon_latency", cyc - acc_cyc, NCHUNK);
                        first = 1'b0;
                    end
                    checkVal("mon_result", {16'b0, result}, {16'b0, exp_q[18:3]});
                    checkVal("mon_cout", {31'b0, cout}, {31'b0, exp_q[2]});
                    checkVal("mon_ovf", {31'b0, ovf}, {31'b0, exp_q[1]});
                    checkVal("mon_zero", {31'b0, zero}, {31'b0, exp_q[0]});
                    if (out_ready) pend = 1'b0;
                end
            end else begin
                checkVal("mon_out_valid_idle", {31'b0, out_valid}, 32'd0);
                if (in_valid) begin
                    exp_q   = model(a, b, sub);
                    acc_cyc = cyc + 1;
                    pend    = 1'b1;
                    first   = 1'b1;
                end
            end
        end
    end

    // Called at posedge+1. Waits for in_ready, presents one operation, then
    // scrambles the inputs and counts edges until out_valid appears.
    task automatic applyStimulus(input logic [15:0] aa, input logic [15:0] bb, input logic ss, output int lat);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) checkVal("accept_timeout", {31'b0, in_ready}, 32'd1);
        a = aa; b = bb; sub = ss; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = ~aa; b = aa ^ bb; sub = !ss;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic checkOutput(input string name, input int lat, input int exp_lat,
                               input logic [15:0] er, input logic ec, input logic eo, input logic ez);
        checkVal({name, "_out_valid"}, {31'b0, out_valid}, 32'd1);
        checkVal({name, "_latency"}, lat, exp_lat);
        checkVal({name, "_result"}, {16'b0, result}, {16'b0, er});
        checkVal({name, "_cout"}, {31'b0, cout}, {31'b0, ec});
        checkVal({name, "_ovf"}, {31'b0, ovf}, {31'b0, eo});
        checkVal({name, "_zero"}, {31'b0, zero}, {31'b0, ez});
    endtask

    initial begin
        int lat;
        logic [15:0] exp_sat;
        rst = 1'b1;
        in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b1;
        in_valid_w = 1'b0; a_w = '0; b_w = '0; sub_w = 1'b0; out_ready_w = 1'b1;

        #12;
        checkVal("reset_in_ready", {31'b0, in_ready}, 32'd1);
        checkVal("reset_out_valid", {31'b0, out_valid}, 32'd0);
        checkVal("reset_result", {16'b0, result}, 32'd0);
        checkVal("reset_flags", {29'b0, cout, ovf, zero}, 32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        applyStimulus(16'hB5EA, 16'h250B, 1'b0, lat);
        checkOutput("add_mixed", lat, 4, 16'hDAF5, 1'b0, 1'b0, 1'b0);

        applyStimulus(16'hB5EA, 16'hFFFA, 1'b1, lat);
        checkOutput("sub_neg", lat, 4, 16'hB5F0, 1'b0, 1'b0, 1'b0);

        applyStimulus(16'h0100, 16'h015E, 1'b1, lat);
        checkOutput("sub_borrow", lat, 4, 16'hFFA2, 1'b0, 1'b0, 1'b0);

`ifdef SEQ_ADDSUB_SAT_EN
        exp_sat = 16'h7FFF;
`else
        exp_sat = 16'hFFFE;
`endif
        applyStimulus(16'h7FFF, 16'h7FFF, 1'b0, lat);
        checkOutput("add_pos_ovf", lat, 4, exp_sat, 1'b0, 1'b1, 1'b0);

        // Abort an operation with a reset pulse in its second RUN cycle.
        @(posedge clk); #1;
        lat = 0;
        while (!in_ready && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        a = 16'h1234; b = 16'h1111; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        checkVal("abort_out_valid", {31'b0, out_valid}, 32'd0);
        checkVal("abort_in_ready", {31'b0, in_ready}, 32'd1);
        checkVal("abort_result", {16'b0, result}, 32'd0);
        checkVal("abort_flags", {29'b0, cout, ovf, zero}, 32'd0);
        @(negedge clk); #2;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        checkVal("abort_no_out_valid", {31'b0, out_valid}, 32'd0);
        applyStimulus(16'h1234, 16'h1111, 1'b0, lat);
        checkOutput("after_abort", lat, 4, 16'h2345, 1'b0, 1'b0, 1'b0);

        // Hold results in DONE while the consumer stalls; in_valid ignored.
        @(posedge clk); #1;
        out_ready = 1'b0;
        applyStimulus(16'h0005, 16'h0005, 1'b1, lat);
        checkOutput("sub_zero", lat, 4, 16'h0000, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; a = 16'h0ABC; b = 16'h0123; sub = 1'b0;
            @(posedge clk); #1;
            checkVal("hold_out_valid", {31'b0, out_valid}, 32'd1);
            checkVal("hold_in_ready", {31'b0, in_ready}, 32'd0);
            checkVal("hold_result", {13'b0, result, cout, ovf, zero}, {13'b0, 16'h0000, 3'b101});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;

        // Negative-side overflow and a wrap-to-zero overflow.
`ifdef SEQ_ADDSUB_SAT_EN
        exp_sat = 16'h8000;
`else
        exp_sat = 16'h7FFF;
`endif
        applyStimulus(16'h8000, 16'h0001, 1'b1, lat);
        checkOutput("sub_neg_ovf", lat, 4, exp_sat, 1'b1, 1'b1, 1'b0);
`ifdef SEQ_ADDSUB_SAT_EN
        applyStimulus(16'h8000, 16'h8000, 1'b0, lat);
        checkOutput("add_min_min", lat, 4, 16'h8000, 1'b1, 1'b1, 1'b0);
`else
        applyStimulus(16'h8000, 16'h8000, 1'b0, lat);
        checkOutput("add_min_min", lat, 4, 16'h0000, 1'b1, 1'b1, 1'b1);
`endif

        // Back-to-back: next op is offered as soon as in_ready returns.
        applyStimulus(16'h0001, 16'hFFFF, 1'b0, lat);
        checkOutput("add_wrap_zero", lat, 4, 16'h0000, 1'b1, 1'b0, 1'b1);
        applyStimulus(16'h4000, 16'hC000, 1'b1, lat);
        checkOutput("sub_ovf_b2b", lat, 4, model(16'h4000, 16'hC000, 1'b1) >> 3, 1'b0, 1'b1, 1'b0);
        @(posedge clk); #1;

        // Single-chunk instance: one-edge latency.
        a_w = 16'h0099; b_w = 16'hFF09; sub_w = 1'b0; in_valid_w = 1'b1;
        @(posedge clk); #1;
        in_valid_w = 1'b0; a_w = 16'hFFFF; b_w = 16'h1234;
        lat = 0;
        while (!out_valid_w && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        checkVal("wide_latency", lat, 1);
        checkVal("wide_result", {16'b0, result_w}, 32'h0000FFA2);
        checkVal("wide_flags", {29'b0, cout_w, ovf_w, zero_w}, 32'd0);
        checkVal("wide_in_ready", {31'b0, in_ready_w}, 32'd0);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
